// File: rtl/input_conditioner_pkg.sv
// Shared sizes and width helpers for the input conditioner.
// BTN_SZ, SW_SZ and CLK_HZ are board-wide macros; the defaults below apply unless the top level overrides them.
`ifndef BTN_SZ
`define BTN_SZ 3
`endif
`ifndef SW_SZ
`define SW_SZ 2
`endif
`ifndef CLK_HZ
`define CLK_HZ 125000000
`endif

package input_conditioner_pkg;

    localparam int unsigned NumBtn       = `BTN_SZ;
    localparam int unsigned NumSw        = `SW_SZ;
    localparam int unsigned DefaultClkHz = `CLK_HZ;

    // Counter width for a modulus of n; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_conditioner_db_filter.sv
// One raw input: 2-flop synchroniser followed by a stability counter that owns the accepted level.
// level_d_o exposes the level that will be accepted at the next edge, so callers can see changes early.
module input_conditioner_db_filter
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 2500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic level_d_o
);

    localparam int unsigned DcW = cnt_w(DB_CYCLES);

    logic           meta_q;
    logic           sync_q;
    logic           acc_q;
    logic           acc_d;
    logic [DcW-1:0] dc_q;
    logic [DcW-1:0] dc_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            acc_q  <= 1'b0;
            dc_q   <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            acc_q  <= acc_d;
            dc_q   <= dc_d;
        end
    end

    // Any cycle where the input agrees with the accepted level restarts the count.
    always_comb begin
        acc_d = acc_q;
        dc_d  = '0;
        if (sync_q != acc_q) begin
            if (dc_q == DcW'(DB_CYCLES - 1)) begin
                acc_d = sync_q;
            end else begin
                dc_d = dc_q + DcW'(1);
            end
        end
    end

    assign level_o   = acc_q;
    assign level_d_o = acc_d;

endmodule

// File: rtl/input_conditioner.sv
// Front end for the traffic-light controller: 1 Hz timebase, debounced switches, one-shot button pulses.
// Define AUTO_REPEAT_EN to add per-button auto-repeat while a button stays held.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned CLK_HZ        = `CLK_HZ,
    parameter int unsigned TICK_HZ       = 1,
    parameter int unsigned DB_CYCLES     = 2500000,
    parameter int unsigned REPEAT_DELAY  = 62500000,
    parameter int unsigned REPEAT_PERIOD = 25000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [`BTN_SZ-1:0] btn_raw_i,
    input  logic [`SW_SZ-1:0]  sw_raw_i,
    output logic              time_o,
    output logic              tick_o,
    output logic [`BTN_SZ-1:0] btn_o,
    output logic [`SW_SZ-1:0]  sw_o
);

    localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned CntW = cnt_w(DIV);

    // ---------------------------------------------------------------- timebase
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            time_q;
    logic            time_d;
    logic            tick_q;
    logic            tick_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            time_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            time_q <= time_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q + CntW'(1);
        tick_d = 1'b0;
        time_d = time_q;
        if (cnt_q == CntW'(DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            time_d = 1'b1;
        end else if (cnt_q == CntW'(DIV / 2 - 1)) begin
            time_d = 1'b0;
        end
    end

    assign time_o = time_q;
    assign tick_o = tick_q;

    // ---------------------------------------------------------------- filters
    logic [NumBtn-1:0] btn_lvl_q;
    logic [NumBtn-1:0] btn_lvl_d;
    logic [NumSw-1:0]  sw_lvl_q;
    logic [NumSw-1:0]  sw_lvl_d;
    logic              unused_sw_lvl_d;

    for (genvar i = 0; i < NumBtn; i++) begin : g_btn
        input_conditioner_db_filter #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db_filter (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .raw_i    (btn_raw_i[i]),
            .level_o  (btn_lvl_q[i]),
            .level_d_o(btn_lvl_d[i])
        );
    end

    for (genvar i = 0; i < NumSw; i++) begin : g_sw
        input_conditioner_db_filter #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db_filter (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .raw_i    (sw_raw_i[i]),
            .level_o  (sw_lvl_q[i]),
            .level_d_o(sw_lvl_d[i])
        );
    end

    assign unused_sw_lvl_d = ^sw_lvl_d;
    assign sw_o            = sw_lvl_q;

    // ---------------------------------------------------------------- button pulses
    logic [NumBtn-1:0] rep_d;
    logic [NumBtn-1:0] btn_q;
    logic [NumBtn-1:0] btn_d;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RcW = cnt_w(max_u(REPEAT_DELAY, REPEAT_PERIOD));

    logic [NumBtn-1:0][RcW-1:0] rc_q;
    logic [NumBtn-1:0][RcW-1:0] rc_d;
    logic [NumBtn-1:0]          armed_q;
    logic [NumBtn-1:0]          armed_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rc_q    <= '0;
            armed_q <= '0;
        end else begin
            rc_q    <= rc_d;
            armed_q <= armed_d;
        end
    end

    // armed_q marks that the first (long) repeat interval has elapsed.
    // Requiring level_d keeps a repeat from landing on the release cycle.
    always_comb begin
        rc_d    = rc_q;
        armed_d = armed_q;
        rep_d   = '0;
        for (int i = 0; i < int'(NumBtn); i++) begin
            if (btn_lvl_q[i] && btn_lvl_d[i]) begin
                if (rc_q[i] == (armed_q[i] ? RcW'(REPEAT_PERIOD - 1) : RcW'(REPEAT_DELAY - 1))) begin
                    rep_d[i]   = 1'b1;
                    rc_d[i]    = '0;
                    armed_d[i] = 1'b1;
                end else begin
                    rc_d[i] = rc_q[i] + RcW'(1);
                end
            end else begin
                rc_d[i]    = '0;
                armed_d[i] = 1'b0;
            end
        end
    end
`else
    localparam int unsigned UnusedRepeat = REPEAT_DELAY + REPEAT_PERIOD;

    assign rep_d = '0;
`endif

    assign btn_d = (btn_lvl_d & ~btn_lvl_q) | rep_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign btn_o = btn_q;

endmodule
